// File: rtl/life_pkg.sv
// Shared types and rule constants for the parametrised Conway life array.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SURVIVE_MIN = 4'd2;
    localparam logic [3:0] SURVIVE_MAX = 4'd3;
    localparam logic [3:0] BIRTH_COUNT = 4'd3;

    function automatic logic [3:0] count_live(input logic [7:0] bits);
        logic [3:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, bits[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/life_cell_next.sv
// Next-state rule for one cell given its eight neighbours.
module life_cell_next
    import life_pkg::*;
(
    input  logic [7:0] nbrs,
    input  logic       alive,
    output logic       next_alive
);

    logic [3:0] live_cnt;

    assign live_cnt = count_live(nbrs);

    always_comb begin
        next_alive = 1'b0;
        if (alive) begin
            next_alive = (live_cnt >= SURVIVE_MIN) && (live_cnt <= SURVIVE_MAX);
        end else begin
            next_alive = (live_cnt == BIRTH_COUNT);
        end
    end

endmodule

// File: rtl/life_grid.sv
// ROWS x COLS life array: row load/readback, previous-generation snapshot,
// edge inputs or toroidal wrap, and a multi-generation run controller.
module life_grid
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    write_enb,
    input  logic [$clog2(ROWS)-1:0] row_sel,
    input  logic [COLS-1:0]         row_wdata,
    output logic [COLS-1:0]         row_rdata,
    output logic [COLS-1:0]         row_rdata_prev,
    input  logic                    wrap,
    input  logic [COLS-1:0]         ni,
    input  logic [COLS-1:0]         si,
    input  logic [ROWS-1:0]         wi,
    input  logic [ROWS-1:0]         ei,
    input  logic                    nwi,
    input  logic                    nei,
    input  logic                    swi,
    input  logic                    sei,
    input  logic                    step,
    input  logic                    start,
    input  logic [GEN_W-1:0]        gen_target,
    input  logic                    stop_on_still,
    output logic                    busy,
    output logic                    done,
    output logic                    stable,
    output logic                    extinct,
    output logic [GEN_W-1:0]        gen_count,
    output logic [1:0]              fsm_state
);

    localparam int EW    = COLS + 2;
    localparam int CELLS = ROWS * COLS;

    state_e state, state_nx;
    logic [CELLS-1:0] cur, prv, nxt, cur_wr, prv_wr;
    logic [(ROWS+2)*EW-1:0] ext;
    logic [GEN_W-1:0] remaining;
    logic do_gen, do_write, load_rem;
    logic nxt_stable, nxt_extinct;
    logic sel_ok;
    int   sel_base;

    // Grid padded by a one-cell ring holding either the wrapped edges or the external inputs.
    always_comb begin
        ext = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                ext[(r+1)*EW + c + 1] = cur[r*COLS + c];
            end
            ext[(r+1)*EW]            = wrap ? cur[r*COLS + COLS - 1] : wi[r];
            ext[(r+1)*EW + COLS + 1] = wrap ? cur[r*COLS]            : ei[r];
        end
        for (int c = 0; c < COLS; c++) begin
            ext[c + 1]                 = wrap ? cur[(ROWS-1)*COLS + c] : ni[c];
            ext[(ROWS+1)*EW + c + 1]   = wrap ? cur[c]                 : si[c];
        end
        ext[0]                         = wrap ? cur[CELLS-1]           : nwi;
        ext[COLS + 1]                  = wrap ? cur[(ROWS-1)*COLS]     : nei;
        ext[(ROWS+1)*EW]               = wrap ? cur[COLS-1]            : swi;
        ext[(ROWS+1)*EW + COLS + 1]    = wrap ? cur[0]                 : sei;
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            life_cell_next u_cell (
                .nbrs       ({ext[gr*EW + gc],     ext[gr*EW + gc + 1],     ext[gr*EW + gc + 2],
                              ext[(gr+1)*EW + gc],                          ext[(gr+1)*EW + gc + 2],
                              ext[(gr+2)*EW + gc], ext[(gr+2)*EW + gc + 1], ext[(gr+2)*EW + gc + 2]}),
                .alive      (cur[gr*COLS + gc]),
                .next_alive (nxt[gr*COLS + gc])
            );
        end
    end

    assign nxt_stable  = (nxt == cur);
    assign nxt_extinct = (nxt == '0);
    assign sel_ok      = (int'(row_sel) < ROWS);
    assign sel_base    = int'(row_sel) * COLS;

    always_comb begin
        cur_wr = cur;
        prv_wr = prv;
        if (sel_ok) begin
            cur_wr[sel_base +: COLS] = row_wdata;
            prv_wr[sel_base +: COLS] = row_wdata;
        end
    end

    // Host requests only act in IDLE; start outranks step, which outranks write.
    always_comb begin
        state_nx = state;
        do_gen   = 1'b0;
        do_write = 1'b0;
        load_rem = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_rem = 1'b1;
                    state_nx = (gen_target != '0) ? ST_RUN : ST_DONE;
                end else if (step) begin
                    do_gen = 1'b1;
                end else if (write_enb) begin
                    do_write = 1'b1;
                end
            end
            ST_RUN: begin
                do_gen = 1'b1;
                if ((remaining == GEN_W'(1)) ||
                    (stop_on_still && (nxt_stable || nxt_extinct))) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur            <= '0;
            prv            <= '0;
            remaining      <= '0;
            gen_count      <= '0;
            stable         <= 1'b0;
            extinct        <= 1'b1;
            row_rdata      <= '0;
            row_rdata_prev <= '0;
        end else begin
            if (load_rem) begin
                remaining <= gen_target;
            end else if (state == ST_RUN) begin
                remaining <= remaining - GEN_W'(1);
            end
            if (do_gen) begin
                prv       <= cur;
                cur       <= nxt;
                gen_count <= gen_count + GEN_W'(1);
                stable    <= nxt_stable;
                extinct   <= nxt_extinct;
            end else if (do_write) begin
                cur     <= cur_wr;
                prv     <= prv_wr;
                stable  <= 1'b0;
                extinct <= (cur_wr == '0);
            end
            row_rdata      <= sel_ok ? cur[sel_base +: COLS] : '0;
            row_rdata_prev <= sel_ok ? prv[sel_base +: COLS] : '0;
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule
